crtc_prog: RTL and testbench

- Programmable-timing CRT controller, next generation of the character-clock CRTC.
- Generates hsync/vsync, blanking, display enable and active row/column from cumulative horizontal/vertical timing thresholds.
- Adds separate H/V counter widths, per-axis sync polarity, frame-boundary shadowing of timing inputs for glitch-free mode changes, line-doubling mode, start-of-line/frame strobes and a line-compare interrupt strobe.
- Sits between the timing-register file and the video fetch/pixel pipeline.

---
 rtl/crtc_prog.sv | 158 +++++++++++++++
 tb/tb_crtc_prog.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crtc_prog.sv
// crtc_prog: programmable-timing CRT controller.
//
// Counts characters (h) and lines (v) against cumulative, inclusive-end timing
// thresholds and produces registered sync, blanking, display-enable, active
// row/column and start-of-line/frame/line-compare strobes.
//
// Ports:
//   clock_i, reset_i       character clock, synchronous active-high reset
//   enable_i               advance one character when high; otherwise hold
//   h*/v* timing inputs    last count of sync/back porch/active/front porch
//   hpol_i, vpol_i         active level of hsync_o / vsync_o
//   dbl_i                  line doubling (row_o = line >> 1)
//   vcmp_i                 line-compare value for vint_o
//   row_o, col_o           active row / column, 0 outside active video
//   de_o, hblank_o, vblank_o, hsync_o, vsync_o   video timing outputs
//   sol_o, sof_o, vint_o   one-enabled-cycle strobes
//
// Timing/polarity/dbl/vcmp inputs are shadowed and only reloaded at the frame
// wrap, so a mode change never produces a torn frame.
module crtc_prog #(
    parameter int unsigned HWIDTH    = 10,
    parameter int unsigned VWIDTH    = 10,
    parameter int unsigned DOUBLE_EN = 1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic [HWIDTH-1:0] hsynct_i,
    input  logic [HWIDTH-1:0] hbporch_i,
    input  logic [HWIDTH-1:0] hactive_i,
    input  logic [HWIDTH-1:0] hfporch_i,
    input  logic [VWIDTH-1:0] vsynct_i,
    input  logic [VWIDTH-1:0] vbporch_i,
    input  logic [VWIDTH-1:0] vactive_i,
    input  logic [VWIDTH-1:0] vfporch_i,
    input  logic              hpol_i,
    input  logic              vpol_i,
    input  logic              dbl_i,
    input  logic [VWIDTH-1:0] vcmp_i,
    output logic [VWIDTH-1:0] row_o,
    output logic [HWIDTH-1:0] col_o,
    output logic              de_o,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic              hblank_o,
    output logic              vblank_o,
    output logic              sol_o,
    output logic              sof_o,
    output logic              vint_o
);

    localparam bit DblAllowed = (DOUBLE_EN != 0);

    // Counter state
    logic [HWIDTH-1:0] h_cnt;
    logic [VWIDTH-1:0] v_cnt;

    // Shadowed programming, valid for the whole current frame
    logic [HWIDTH-1:0] hsynct_s, hbporch_s, hactive_s, hfporch_s;
    logic [VWIDTH-1:0] vsynct_s, vbporch_s, vactive_s, vfporch_s;
    logic              hpol_s, vpol_s, dbl_s;
    logic [VWIDTH-1:0] vcmp_s;

    // Next-state and decoded values
    logic              h_last, v_last, frame_end;
    logic [HWIDTH-1:0] h_next;
    logic [VWIDTH-1:0] v_next;
    logic              h_sync, h_act, v_sync, v_act;
    logic [HWIDTH-1:0] col_next;
    logic [VWIDTH-1:0] line, row_next;

    always_comb begin
        h_last    = (h_cnt == hfporch_s);
        v_last    = (v_cnt == vfporch_s);
        frame_end = h_last && v_last;

        // Wrap only at fporch, so out-of-order thresholds cannot stall counting
        h_next = h_last ? '0 : h_cnt + HWIDTH'(1);
        v_next = v_cnt;
        if (h_last) begin
            v_next = v_last ? '0 : v_cnt + VWIDTH'(1);
        end

        h_sync = (h_cnt <= hsynct_s);
        h_act  = (h_cnt > hbporch_s) && (h_cnt <= hactive_s);
        v_sync = (v_cnt <= vsynct_s);
        v_act  = (v_cnt > vbporch_s) && (v_cnt <= vactive_s);

        col_next = h_act ? (h_cnt - hbporch_s - HWIDTH'(1)) : '0;
        line     = v_cnt - vbporch_s - VWIDTH'(1);
        row_next = '0;
        if (v_act) begin
            row_next = (DblAllowed && dbl_s) ? (line >> 1) : line;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            h_cnt     <= '0;
            v_cnt     <= '0;
            hsynct_s  <= hsynct_i;
            hbporch_s <= hbporch_i;
            hactive_s <= hactive_i;
            hfporch_s <= hfporch_i;
            vsynct_s  <= vsynct_i;
            vbporch_s <= vbporch_i;
            vactive_s <= vactive_i;
            vfporch_s <= vfporch_i;
            hpol_s    <= hpol_i;
            vpol_s    <= vpol_i;
            dbl_s     <= dbl_i;
            vcmp_s    <= vcmp_i;
            // Sync outputs idle at the inactive level of the incoming polarity
            hsync_o   <= ~hpol_i;
            vsync_o   <= ~vpol_i;
            de_o      <= 1'b0;
            hblank_o  <= 1'b1;
            vblank_o  <= 1'b1;
            row_o     <= '0;
            col_o     <= '0;
            sol_o     <= 1'b0;
            sof_o     <= 1'b0;
            vint_o    <= 1'b0;
        end else if (enable_i) begin
            h_cnt <= h_next;
            v_cnt <= v_next;

            // New programming lands exactly when the counters return to (0,0)
            if (frame_end) begin
                hsynct_s  <= hsynct_i;
                hbporch_s <= hbporch_i;
                hactive_s <= hactive_i;
                hfporch_s <= hfporch_i;
                vsynct_s  <= vsynct_i;
                vbporch_s <= vbporch_i;
                vactive_s <= vactive_i;
                vfporch_s <= vfporch_i;
                hpol_s    <= hpol_i;
                vpol_s    <= vpol_i;
                dbl_s     <= dbl_i;
                vcmp_s    <= vcmp_i;
            end

            // Outputs reflect the counter state being left this cycle
            hsync_o  <= h_sync ? hpol_s : ~hpol_s;
            vsync_o  <= v_sync ? vpol_s : ~vpol_s;
            hblank_o <= ~h_act;
            vblank_o <= ~v_act;
            de_o     <= h_act && v_act;
            col_o    <= col_next;
            row_o    <= row_next;
            sol_o    <= (h_cnt == '0);
            sof_o    <= (h_cnt == '0) && (v_cnt == '0);
            vint_o   <= (h_cnt == '0) && (v_cnt == vcmp_s);
        end
    end

endmodule

// File: tb/tb_crtc_prog.sv
// Self-checking bench for crtc_prog: directed timing modes with hand-computed
// per-frame statistics (counts, maxima, periods) and point checks.
module tb_crtc_prog;

    localparam int HW = 10;
    localparam int VW = 10;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          enable_i = 1'b0;
    logic [HW-1:0] hsynct_i, hbporch_i, hactive_i, hfporch_i;
    logic [VW-1:0] vsynct_i, vbporch_i, vactive_i, vfporch_i;
    logic          hpol_i = 1'b0, vpol_i = 1'b0, dbl_i = 1'b0;
    logic [VW-1:0] vcmp_i;
    logic [VW-1:0] row_o;
    logic [HW-1:0] col_o;
    logic          de_o, hsync_o, vsync_o, hblank_o, vblank_o, sol_o, sof_o, vint_o;

    always #5 clk = ~clk;

    crtc_prog #(
        .HWIDTH   (HW),
        .VWIDTH   (VW),
        .DOUBLE_EN(1)
    ) dut (
        .clock_i  (clk),
        .reset_i  (reset_i),
        .enable_i (enable_i),
        .hsynct_i (hsynct_i),
        .hbporch_i(hbporch_i),
        .hactive_i(hactive_i),
        .hfporch_i(hfporch_i),
        .vsynct_i (vsynct_i),
        .vbporch_i(vbporch_i),
        .vactive_i(vactive_i),
        .vfporch_i(vfporch_i),
        .hpol_i   (hpol_i),
        .vpol_i   (vpol_i),
        .dbl_i    (dbl_i),
        .vcmp_i   (vcmp_i),
        .row_o    (row_o),
        .col_o    (col_o),
        .de_o     (de_o),
        .hsync_o  (hsync_o),
        .vsync_o  (vsync_o),
        .hblank_o (hblank_o),
        .vblank_o (vblank_o),
        .sol_o    (sol_o),
        .sof_o    (sof_o),
        .vint_o   (vint_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Statistics gathered over a window of samples
    int cyc = 0;
    int samp, de_cnt, hs_low, vs_low, hb_cnt, vb_cnt, de_err, col_err;
    int max_col, max_row, sol_cnt, sof_cnt, vint_cnt, vint_samp, vint_row;
    int last_sol_cyc, sol_period, row_idx;
    int rows [16];
    logic prev_de, prev_sol, prev_sof, prev_vint;
    int   prev_col;

    task automatic clear_stats();
        samp = 0; de_cnt = 0; hs_low = 0; vs_low = 0; hb_cnt = 0; vb_cnt = 0;
        de_err = 0; col_err = 0; max_col = -1; max_row = -1;
        sol_cnt = 0; sof_cnt = 0; vint_cnt = 0; vint_samp = -1; vint_row = -1;
        last_sol_cyc = -1; sol_period = -1; row_idx = 0;
        prev_de = de_o; prev_col = int'(col_o);
        prev_sol = sol_o; prev_sof = sof_o; prev_vint = vint_o;
    endtask

    task automatic tally();
        samp++;
        if (!hsync_o) hs_low++;
        if (!vsync_o) vs_low++;
        if (hblank_o) hb_cnt++;
        if (vblank_o) vb_cnt++;
        if (de_o != (!hblank_o && !vblank_o)) de_err++;
        if (de_o) begin
            de_cnt++;
            if (int'(col_o) > max_col) max_col = int'(col_o);
            if (int'(row_o) > max_row) max_row = int'(row_o);
            if (prev_de) begin
                if (int'(col_o) != prev_col + 1) col_err++;
            end else begin
                if (col_o != '0) col_err++;
                if (row_idx < 16) begin
                    rows[row_idx] = int'(row_o);
                    row_idx++;
                end
            end
        end
        if (sol_o && !prev_sol) begin
            sol_cnt++;
            if (last_sol_cyc >= 0) sol_period = cyc - last_sol_cyc;
            last_sol_cyc = cyc;
        end
        if (sof_o && !prev_sof) sof_cnt++;
        if (vint_o && !prev_vint) begin
            vint_cnt++;
            vint_samp = samp;
            vint_row  = int'(row_o);
        end
        prev_de = de_o; prev_col = int'(col_o);
        prev_sol = sol_o; prev_sof = sof_o; prev_vint = vint_o;
    endtask

    task automatic step(input logic en);
        enable_i = en;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1);
            tally();
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        step(1'b1);
        reset_i = 1'b0;
    endtask

    task automatic check_reset_out(input string tag, input logic exp_hs, input logic exp_vs);
        check_eq({tag, "_hsync"}, 32'(hsync_o), 32'(exp_hs));
        check_eq({tag, "_vsync"}, 32'(vsync_o), 32'(exp_vs));
        check_eq({tag, "_de"}, 32'(de_o), 0);
        check_eq({tag, "_hblank"}, 32'(hblank_o), 1);
        check_eq({tag, "_vblank"}, 32'(vblank_o), 1);
        check_eq({tag, "_row"}, 32'(row_o), 0);
        check_eq({tag, "_col"}, 32'(col_o), 0);
        check_eq({tag, "_sol"}, 32'(sol_o), 0);
        check_eq({tag, "_sof"}, 32'(sof_o), 0);
        check_eq({tag, "_vint"}, 32'(vint_o), 0);
    endtask

    // Small mode: line 12 clocks (sync h0-1, active h4-9), frame 13 lines
    // (sync v0, active v3-10), 156 clocks per frame.
    task automatic set_small();
        hsynct_i = 10'd1; hbporch_i = 10'd3; hactive_i = 10'd9;  hfporch_i = 10'd11;
        vsynct_i = 10'd0; vbporch_i = 10'd2; vactive_i = 10'd10; vfporch_i = 10'd12;
        vcmp_i   = 10'd20;
    endtask

    logic [29:0] snap;
    int          hold_err;

    initial begin
        // ---------------- VGA 640x480, one full frame ----------------
        hsynct_i = 10'd11; hbporch_i = 10'd17; hactive_i = 10'd97; hfporch_i = 10'd99;
        vsynct_i = 10'd1;  vbporch_i = 10'd34; vactive_i = 10'd514; vfporch_i = 10'd524;
        hpol_i = 1'b0; vpol_i = 1'b0; dbl_i = 1'b0; vcmp_i = 10'd40;
        step(1'b0);
        do_reset();
        check_reset_out("vga_rst", 1'b1, 1'b1);
        clear_stats();
        run(1);
        check_eq("vga_first_sof", 32'(sof_o), 1);
        check_eq("vga_first_hsync", 32'(hsync_o), 0);
        run(52499);
        check_eq("vga_sof_cnt", sof_cnt, 1);
        check_eq("vga_sol_cnt", sol_cnt, 525);
        check_eq("vga_line_period", sol_period, 100);
        check_eq("vga_de_cnt", de_cnt, 38400);
        check_eq("vga_hsync_low", hs_low, 6300);
        check_eq("vga_vsync_low", vs_low, 200);
        check_eq("vga_hblank_cnt", hb_cnt, 10500);
        check_eq("vga_vblank_cnt", vb_cnt, 4500);
        check_eq("vga_max_col", max_col, 79);
        check_eq("vga_max_row", max_row, 479);
        check_eq("vga_col_seq", col_err, 0);
        check_eq("vga_de_consistent", de_err, 0);
        check_eq("vga_vint_cnt", vint_cnt, 1);
        check_eq("vga_vint_pos", vint_samp, 4001);
        check_eq("vga_vint_row", vint_row, 5);
        run(1);
        check_eq("vga_frame_period_sof", 32'(sof_o), 1);

        // ---------------- line doubling ----------------
        set_small();
        dbl_i = 1'b1;
        do_reset();
        clear_stats();
        run(156);
        check_eq("dbl_lines", row_idx, 8);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("dbl_row%0d", i), 32'(rows[i]), 32'(i >> 1));
        end
        check_eq("dbl_max_row", max_row, 3);
        check_eq("dbl_de_cnt", de_cnt, 48);
        check_eq("dbl_vint_none", vint_cnt, 0);

        // ---------------- hactive change mid-frame ----------------
        set_small();
        dbl_i = 1'b0;
        do_reset();
        clear_stats();
        run(78);
        hactive_i = 10'd7;
        run(78);
        check_eq("hact_cur_max_col", max_col, 5);
        check_eq("hact_cur_de_cnt", de_cnt, 48);
        clear_stats();
        run(156);
        check_eq("hact_new_sof", sof_cnt, 1);
        check_eq("hact_new_max_col", max_col, 3);
        check_eq("hact_new_de_cnt", de_cnt, 32);
        check_eq("hact_new_col_seq", col_err, 0);

        // ---------------- polarity, mid-frame flip deferred ----------------
        set_small();
        hpol_i = 1'b1; vpol_i = 1'b1;
        do_reset();
        check_reset_out("pol_rst", 1'b0, 1'b0);
        clear_stats();
        run(78);
        hpol_i = 1'b0;
        run(78);
        check_eq("pol_hsync_low", hs_low, 130);
        check_eq("pol_vsync_low", vs_low, 144);
        check_eq("pol_vcmp_beyond", vint_cnt, 0);
        clear_stats();
        run(156);
        check_eq("pol_flip_hsync_low", hs_low, 26);
        check_eq("pol_keep_vsync_low", vs_low, 144);

        // ---------------- enable toggling ----------------
        set_small();
        hpol_i = 1'b0; vpol_i = 1'b0;
        do_reset();
        clear_stats();
        hold_err = 0;
        for (int i = 0; i < 120; i++) begin
            step(1'b1);
            tally();
            snap = {row_o, col_o, de_o, hsync_o, vsync_o, hblank_o, vblank_o,
                    sol_o, sof_o, vint_o};
            step(1'b0);
            tally();
            if (snap !== {row_o, col_o, de_o, hsync_o, vsync_o, hblank_o, vblank_o,
                          sol_o, sof_o, vint_o}) hold_err++;
        end
        check_eq("en_line_period", sol_period, 24);
        check_eq("en_hold", hold_err, 0);
        check_eq("en_sol_cnt", sol_cnt, 10);

        // ---------------- reset mid-frame, enable low ----------------
        set_small();
        do_reset();
        clear_stats();
        run(77);
        // Last sample shows (h=4, v=6): first active column of line 3
        check_eq("midrst_pre_de", 32'(de_o), 1);
        check_eq("midrst_pre_row", 32'(row_o), 3);
        reset_i = 1'b1;
        step(1'b0);
        reset_i = 1'b0;
        check_reset_out("midrst", 1'b1, 1'b1);
        step(1'b1);
        check_eq("midrst_sof", 32'(sof_o), 1);
        check_eq("midrst_sol", 32'(sol_o), 1);
        check_eq("midrst_hsync", 32'(hsync_o), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
